// File: rtl/vga_pkg.sv
// Shared VGA timing description and text-glyph geometry for the overlay blocks.
package vga_pkg;

  typedef struct packed {
    int pixel_x_bits;
    int pixel_y_bits;
    int h_visible;
    int v_visible;
  } vga_params_t;

  localparam int GLYPH_W = 8;
  localparam int GLYPH_H = 16;

  localparam vga_params_t VGA_640X480 = '{
    pixel_x_bits: 10, pixel_y_bits: 10, h_visible: 640, v_visible: 480
  };

endpackage

// File: rtl/font_rom_8x16.sv
// Standard IBM VGA 8x16 font for printable ASCII; every other code renders blank.
module font_rom_8x16 (
  input  logic [7:0] char_code,
  input  logic [3:0] glyph_row,
  output logic [7:0] row_bits
);

  // Each glyph is 16 rows of 8 bits, top row in the most significant byte.
  logic [127:0] glyph;

  always_comb begin
    glyph = '0;
    case (char_code)
      8'h21: glyph = 128'h0000_183c_3c3c_1818_1800_1818_0000_0000;
      8'h22: glyph = 128'h0066_6666_2400_0000_0000_0000_0000_0000;
      8'h23: glyph = 128'h0000_006c_6cfe_6c6c_6cfe_6c6c_0000_0000;
      8'h24: glyph = 128'h1818_7cc6_c2c0_7c06_0686_c67c_1818_0000;
      8'h25: glyph = 128'h0000_0000_c2c6_0c18_3060_c686_0000_0000;
      8'h26: glyph = 128'h0000_386c_6c38_76dc_cccc_cc76_0000_0000;
      8'h27: glyph = 128'h0030_3030_6000_0000_0000_0000_0000_0000;
      8'h28: glyph = 128'h0000_0c18_3030_3030_3030_180c_0000_0000;
      8'h29: glyph = 128'h0000_3018_0c0c_0c0c_0c0c_1830_0000_0000;
      8'h2a: glyph = 128'h0000_0000_0066_3cff_3c66_0000_0000_0000;
      8'h2b: glyph = 128'h0000_0000_0018_187e_1818_0000_0000_0000;
      8'h2c: glyph = 128'h0000_0000_0000_0000_0018_1818_3000_0000;
      8'h2d: glyph = 128'h0000_0000_0000_00fe_0000_0000_0000_0000;
      8'h2e: glyph = 128'h0000_0000_0000_0000_0000_1818_0000_0000;
      8'h2f: glyph = 128'h0000_0000_0206_0c18_3060_c080_0000_0000;
      8'h30: glyph = 128'h0000_386c_c6c6_d6d6_c6c6_6c38_0000_0000;
      8'h31: glyph = 128'h0000_1838_7818_1818_1818_187e_0000_0000;
      8'h32: glyph = 128'h0000_7cc6_060c_1830_60c0_c6fe_0000_0000;
      8'h33: glyph = 128'h0000_7cc6_0606_3c06_0606_c67c_0000_0000;
      8'h34: glyph = 128'h0000_0c1c_3c6c_ccfe_0c0c_0c1e_0000_0000;
      8'h35: glyph = 128'h0000_fec0_c0c0_fc06_0606_c67c_0000_0000;
      8'h36: glyph = 128'h0000_3860_c0c0_fcc6_c6c6_c67c_0000_0000;
      8'h37: glyph = 128'h0000_fec6_0606_0c18_3030_3030_0000_0000;
      8'h38: glyph = 128'h0000_7cc6_c6c6_7cc6_c6c6_c67c_0000_0000;
      8'h39: glyph = 128'h0000_7cc6_c6c6_7e06_0606_0c78_0000_0000;
      8'h3a: glyph = 128'h0000_0000_1818_0000_0018_1800_0000_0000;
      8'h3b: glyph = 128'h0000_0000_1818_0000_0018_1830_0000_0000;
      8'h3c: glyph = 128'h0000_0006_0c18_3060_3018_0c06_0000_0000;
      8'h3d: glyph = 128'h0000_0000_007e_0000_7e00_0000_0000_0000;
      8'h3e: glyph = 128'h0000_0060_3018_0c06_0c18_3060_0000_0000;
      8'h3f: glyph = 128'h0000_7cc6_c60c_1818_1800_1818_0000_0000;
      8'h40: glyph = 128'h0000_007c_c6c6_dede_dedc_c07c_0000_0000;
      8'h41: glyph = 128'h0000_1038_6cc6_c6fe_c6c6_c6c6_0000_0000;
      8'h42: glyph = 128'h0000_fc66_6666_7c66_6666_66fc_0000_0000;
      8'h43: glyph = 128'h0000_3c66_c2c0_c0c0_c0c2_663c_0000_0000;
      8'h44: glyph = 128'h0000_f86c_6666_6666_6666_6cf8_0000_0000;
      8'h45: glyph = 128'h0000_fe66_6268_7868_6062_66fe_0000_0000;
      8'h46: glyph = 128'h0000_fe66_6268_7868_6060_60f0_0000_0000;
      8'h47: glyph = 128'h0000_3c66_c2c0_c0de_c6c6_663a_0000_0000;
      8'h48: glyph = 128'h0000_c6c6_c6c6_fec6_c6c6_c6c6_0000_0000;
      8'h49: glyph = 128'h0000_3c18_1818_1818_1818_183c_0000_0000;
      8'h4a: glyph = 128'h0000_1e0c_0c0c_0c0c_cccc_cc78_0000_0000;
      8'h4b: glyph = 128'h0000_e666_666c_7878_6c66_66e6_0000_0000;
      8'h4c: glyph = 128'h0000_f060_6060_6060_6062_66fe_0000_0000;
      8'h4d: glyph = 128'h0000_c6ee_fefe_d6c6_c6c6_c6c6_0000_0000;
      8'h4e: glyph = 128'h0000_c6e6_f6fe_dece_c6c6_c6c6_0000_0000;
      8'h4f: glyph = 128'h0000_7cc6_c6c6_c6c6_c6c6_c67c_0000_0000;
      8'h50: glyph = 128'h0000_fc66_6666_7c60_6060_60f0_0000_0000;
      8'h51: glyph = 128'h0000_7cc6_c6c6_c6c6_c6d6_de7c_0c0e_0000;
      8'h52: glyph = 128'h0000_fc66_6666_7c6c_6666_66e6_0000_0000;
      8'h53: glyph = 128'h0000_7cc6_c660_380c_06c6_c67c_0000_0000;
      8'h54: glyph = 128'h0000_7e7e_5a18_1818_1818_183c_0000_0000;
      8'h55: glyph = 128'h0000_c6c6_c6c6_c6c6_c6c6_c67c_0000_0000;
      8'h56: glyph = 128'h0000_c6c6_c6c6_c6c6_c66c_3810_0000_0000;
      8'h57: glyph = 128'h0000_c6c6_c6c6_d6d6_d6fe_ee6c_0000_0000;
      8'h58: glyph = 128'h0000_c6c6_6c7c_3838_7c6c_c6c6_0000_0000;
      8'h59: glyph = 128'h0000_6666_6666_3c18_1818_183c_0000_0000;
      8'h5a: glyph = 128'h0000_fec6_860c_1830_60c2_c6fe_0000_0000;
      8'h5b: glyph = 128'h0000_3c30_3030_3030_3030_303c_0000_0000;
      8'h5c: glyph = 128'h0000_0080_c0e0_7038_1c0e_0602_0000_0000;
      8'h5d: glyph = 128'h0000_3c0c_0c0c_0c0c_0c0c_0c3c_0000_0000;
      8'h5e: glyph = 128'h1038_6cc6_0000_0000_0000_0000_0000_0000;
      8'h5f: glyph = 128'h0000_0000_0000_0000_0000_0000_00ff_0000;
      8'h60: glyph = 128'h3030_1800_0000_0000_0000_0000_0000_0000;
      8'h61: glyph = 128'h0000_0000_0078_0c7c_cccc_cc76_0000_0000;
      8'h62: glyph = 128'h0000_e060_6078_6c66_6666_667c_0000_0000;
      8'h63: glyph = 128'h0000_0000_007c_c6c0_c0c0_c67c_0000_0000;
      8'h64: glyph = 128'h0000_1c0c_0c3c_6ccc_cccc_cc76_0000_0000;
      8'h65: glyph = 128'h0000_0000_007c_c6fe_c0c0_c67c_0000_0000;
      8'h66: glyph = 128'h0000_1c36_3230_7830_3030_3078_0000_0000;
      8'h67: glyph = 128'h0000_0000_0076_cccc_cccc_cc7c_0ccc_7800;
      8'h68: glyph = 128'h0000_e060_606c_7666_6666_66e6_0000_0000;
      8'h69: glyph = 128'h0000_1818_0038_1818_1818_183c_0000_0000;
      8'h6a: glyph = 128'h0000_0606_000e_0606_0606_0606_6666_3c00;
      8'h6b: glyph = 128'h0000_e060_6066_6c78_786c_66e6_0000_0000;
      8'h6c: glyph = 128'h0000_3818_1818_1818_1818_183c_0000_0000;
      8'h6d: glyph = 128'h0000_0000_00ec_fed6_d6d6_d6c6_0000_0000;
      8'h6e: glyph = 128'h0000_0000_00dc_6666_6666_6666_0000_0000;
      8'h6f: glyph = 128'h0000_0000_007c_c6c6_c6c6_c67c_0000_0000;
      8'h70: glyph = 128'h0000_0000_00dc_6666_6666_667c_6060_f000;
      8'h71: glyph = 128'h0000_0000_0076_cccc_cccc_cc7c_0c0c_1e00;
      8'h72: glyph = 128'h0000_0000_00dc_7666_6060_60f0_0000_0000;
      8'h73: glyph = 128'h0000_0000_007c_c660_380c_c67c_0000_0000;
      8'h74: glyph = 128'h0000_1030_30fc_3030_3030_361c_0000_0000;
      8'h75: glyph = 128'h0000_0000_00cc_cccc_cccc_cc76_0000_0000;
      8'h76: glyph = 128'h0000_0000_0066_6666_6666_3c18_0000_0000;
      8'h77: glyph = 128'h0000_0000_00c6_c6d6_d6d6_fe6c_0000_0000;
      8'h78: glyph = 128'h0000_0000_00c6_6c38_3838_6cc6_0000_0000;
      8'h79: glyph = 128'h0000_0000_00c6_c6c6_c6c6_c67e_060c_f800;
      8'h7a: glyph = 128'h0000_0000_00fe_cc18_3060_c6fe_0000_0000;
      8'h7b: glyph = 128'h0000_0e18_1818_7018_1818_180e_0000_0000;
      8'h7c: glyph = 128'h0000_1818_1818_0018_1818_1818_0000_0000;
      8'h7d: glyph = 128'h0000_7018_1818_0e18_1818_1870_0000_0000;
      8'h7e: glyph = 128'h0076_dc00_0000_0000_0000_0000_0000_0000;
      default: glyph = '0;
    endcase
    row_bits = glyph[{~glyph_row, 3'b000} +: 8];
  end

endmodule

// File: rtl/telemetry_box.sv
// Text overlay: renders a NUM_ROWS x NUM_COLS character grid as a 1-bit pixel stream
// anchored at (BOX_X0, BOX_Y0), with a combinational and a registered output.
module telemetry_box
  import vga_pkg::*;
#(
  parameter vga_params_t params   = VGA_640X480,
  parameter int          BOX_X0   = 0,
  parameter int          BOX_Y0   = 0,
  parameter int          NUM_COLS = 16,
  parameter int          NUM_ROWS = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [params.pixel_x_bits-1:0] pixel_x_target_next,
  input  logic [params.pixel_y_bits-1:0] pixel_y_target_next,
  input  logic [7:0]                     chars [NUM_ROWS][NUM_COLS],
  output logic                           pixel_value_next,
  output logic                           pixel_value
);

  localparam int COL_W = (NUM_COLS > 1) ? $clog2(NUM_COLS) : 1;
  localparam int ROW_W = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

  int               x, y, dx, dy;
  logic             in_box;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic [7:0]       char_code;
  logic [3:0]       glyph_row;
  logic [2:0]       glyph_col;
  logic [7:0]       row_bits;

  // NOTE: every always_comb output gets a default up front so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    x      = int'(pixel_x_target_next);
    y      = int'(pixel_y_target_next);
    in_box = (x >= BOX_X0) && (x < BOX_X0 + GLYPH_W * NUM_COLS) &&
             (y >= BOX_Y0) && (y < BOX_Y0 + GLYPH_H * NUM_ROWS);
    dx     = in_box ? x - BOX_X0 : 0;
    dy     = in_box ? y - BOX_Y0 : 0;
    col       = COL_W'(dx / GLYPH_W);
    row       = ROW_W'(dy / GLYPH_H);
    glyph_col = dx[2:0];
    glyph_row = dy[3:0];
    // Outside the box row/col are forced to cell 0, so the index stays in range.
    char_code = chars[row][col];
  end

  font_rom_8x16 u_font (
    .char_code (char_code),
    .glyph_row (glyph_row),
    .row_bits  (row_bits)
  );

  assign pixel_value_next = in_box & row_bits[3'd7 - glyph_col];

  // NOTE: sequential state is written with non-blocking assignments so every flop
  // samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) pixel_value <= 1'b0;
    else       pixel_value <= pixel_value_next;
  end

endmodule

// File: tb/tb_telemetry_box.sv
// Directed self-checking bench for telemetry_box on a 7x15 box anchored at (0,100).
module tb_telemetry_box;
  import vga_pkg::*;

  localparam int BOX_X0   = 0;
  localparam int BOX_Y0   = 100;
  localparam int NUM_ROWS = 7;
  localparam int NUM_COLS = 15;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] px, py;
  logic [7:0] chars [NUM_ROWS][NUM_COLS];
  logic       pixel_value_next, pixel_value;

  int checks   = 0;
  int failures = 0;

  telemetry_box #(
    .params(VGA_640X480), .BOX_X0(BOX_X0), .BOX_Y0(BOX_Y0),
    .NUM_COLS(NUM_COLS), .NUM_ROWS(NUM_ROWS)
  ) dut (
    .clk                 (clk),
    .reset               (reset),
    .pixel_x_target_next (px),
    .pixel_y_target_next (py),
    .chars               (chars),
    .pixel_value_next    (pixel_value_next),
    .pixel_value         (pixel_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Hand-transcribed rows of the glyphs the bench draws (VGA 8x16, top row first).
  function automatic logic glyph_bit(input logic [7:0] code, input int gy, input int gx);
    logic [127:0] g;
    case (code)
      8'h23:   g = 128'h0000_006c_6cfe_6c6c_6cfe_6c6c_0000_0000; // '#'
      8'h39:   g = 128'h0000_7cc6_c6c6_7e06_0606_0c78_0000_0000; // '9'
      8'h41:   g = 128'h0000_1038_6cc6_c6fe_c6c6_c6c6_0000_0000; // 'A'
      8'h5e:   g = 128'h1038_6cc6_0000_0000_0000_0000_0000_0000; // '^'
      default: g = '0;
    endcase
    return g[127 - 8 * gy - gx];
  endfunction

  task automatic fill(input logic [7:0] code);
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        chars[r][c] = code;
  endtask

  task automatic probe(input int x, input int y);
    px = 10'(x);
    py = 10'(y);
    #1;
  endtask

  initial begin
    int ones;
    int xs[6] = '{0, 7, 3, 6, 200, 1};
    int ys[6] = '{107, 107, 100, 105, 300, 111};
    int prev_exp;

    // Reset state; the combinational path ignores reset.
    reset = 1'b1;
    fill(8'h20);
    chars[0][0] = 8'h41;
    probe(0, 107);
    repeat (2) @(posedge clk);
    #1;
    check("reset_pixel_value", pixel_value, 0);
    check("reset_next_unaffected", pixel_value_next, 1);
    @(negedge clk);
    reset = 1'b0;

    // 1: all spaces, full-screen sweep.
    fill(8'h20);
    ones = 0;
    for (int y = 0; y < 480; y++)
      for (int x = 0; x < 640; x++) begin
        probe(x, y);
        if (pixel_value_next !== 1'b0) ones++;
      end
    check("t1_sweep_ones", ones, 0);

    // 2: single 'A' at the top-left cell.
    chars[0][0] = 8'h41;
    for (int y = 100; y < 116; y++)
      for (int x = 0; x < 8; x++) begin
        probe(x, y);
        check($sformatf("t2_A x=%0d y=%0d", x, y), pixel_value_next, glyph_bit(8'h41, y - 100, x));
      end
    ones = 0;
    for (int x = 0; x < 8; x++) begin
      probe(x, 99);
      if (pixel_value_next !== 1'b0) ones++;
      probe(x, 116);
      if (pixel_value_next !== 1'b0) ones++;
    end
    check("t2_rows_99_116_ones", ones, 0);

    // 3: all '#', right and bottom box edges.
    fill(8'h23);
    for (int y = 100; y < 116; y++)
      for (int x = 112; x < 120; x++) begin
        probe(x, y);
        check($sformatf("t3_right x=%0d y=%0d", x, y), pixel_value_next, glyph_bit(8'h23, y - 100, x - 112));
      end
    for (int y = 196; y < 212; y++)
      for (int x = 0; x < 8; x++) begin
        probe(x, y);
        check($sformatf("t3_bottom x=%0d y=%0d", x, y), pixel_value_next, glyph_bit(8'h23, y - 196, x));
      end
    ones = 0;
    for (int y = 100; y < 212; y++) begin
      probe(120, y);
      if (pixel_value_next !== 1'b0) ones++;
    end
    check("t3_x120_ones", ones, 0);
    ones = 0;
    for (int x = 0; x < 120; x++) begin
      probe(x, 212);
      if (pixel_value_next !== 1'b0) ones++;
    end
    check("t3_y212_ones", ones, 0);
    for (int x = 112; x < 120; x++) begin
      probe(x, 211);
      check($sformatf("t3_y211 x=%0d", x), pixel_value_next, glyph_bit(8'h23, 15, x - 112));
    end

    // 4: distinct code per cell; cell [6][14] is '9', cell [0][0] is '^'.
    for (int r = 0; r < NUM_ROWS; r++)
      for (int c = 0; c < NUM_COLS; c++)
        chars[r][c] = 8'(33 + (r * NUM_COLS + c + 14) % 94);
    chars[0][0] = 8'h5e;
    for (int y = 196; y < 212; y++)
      for (int x = 112; x < 120; x++) begin
        probe(x, y);
        check($sformatf("t4_nine x=%0d y=%0d", x, y), pixel_value_next, glyph_bit(8'h39, y - 196, x - 112));
      end
    for (int y = 100; y < 104; y++)
      for (int x = 0; x < 8; x++) begin
        probe(x, y);
        check($sformatf("t4_caret x=%0d y=%0d", x, y), pixel_value_next, glyph_bit(8'h5e, y - 100, x));
      end

    // 5: non-printable codes render blank; 'A' in the same cell proves the address.
    fill(8'h20);
    chars[2][3] = 8'h41;
    for (int x = 24; x < 32; x++) begin
      probe(x, 137);
      check($sformatf("t5_A x=%0d", x), pixel_value_next, glyph_bit(8'h41, 5, x - 24));
    end
    for (int k = 0; k < 2; k++) begin
      chars[2][3] = (k == 0) ? 8'h01 : 8'h80;
      ones = 0;
      for (int y = 132; y < 148; y++)
        for (int x = 24; x < 32; x++) begin
          probe(x, y);
          if (pixel_value_next !== 1'b0) ones++;
        end
      check($sformatf("t5_code_%02h_ones", chars[2][3]), ones, 0);
    end

    // 6: registered path follows pixel_value_next by one clock.
    fill(8'h20);
    chars[0][0] = 8'h41;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      probe(xs[i], ys[i]);
      prev_exp = (xs[i] < 8 && ys[i] >= 100 && ys[i] < 116) ? int'(glyph_bit(8'h41, ys[i] - 100, xs[i])) : 0;
      @(posedge clk);
      #1;
      check($sformatf("t6_reg x=%0d y=%0d", xs[i], ys[i]), pixel_value, prev_exp);
    end

    // Reset mid-glyph on a lit pixel: 'A' row 7 is 0xfe, so x=0 is lit.
    @(negedge clk);
    probe(0, 107);
    @(posedge clk);
    #1;
    check("t6_lit_before_reset", pixel_value, 1);
    #1;
    reset = 1'b1;
    #1;
    check("t6_async_clear", pixel_value, 0);
    @(posedge clk);
    #1;
    check("t6_held_in_reset", pixel_value, 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t6_zero_after_release", pixel_value, 0);
    @(posedge clk);
    #1;
    check("t6_first_edge_after_release", pixel_value, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
